// File: rtl/ss_scan_decoder.sv
// ss_scan_decoder: decodes a multiplexed active-low 7-segment scan back into a hex word
// Ports:
//   i_clk        system clock, posedge
//   i_rst        asynchronous active-high reset
//   i_seg        segment cathodes {g,f,e,d,c,b,a}, active-low
//   i_an         digit anodes, active-low, one low bit selects that digit
//   o_value      last complete frame, digit i in o_value[4*i+3:4*i]
//   o_value_vld  one-cycle pulse when o_value/o_digit_err update
//   o_digit_err  per-digit unrecognised-pattern flags of the last frame
//   i_dp/o_dp_out  decimal point in (active-low) / per-digit out (active-high),
//                  present only when SS_SCAN_DP_EN is defined
module ss_scan_decoder #(
  parameter int DIGITS     = 4,
  parameter int STABLE_CYC = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [6:0]            i_seg,
  input  logic [DIGITS-1:0]     i_an,
`ifdef SS_SCAN_DP_EN
  input  logic                  i_dp,
  output logic [DIGITS-1:0]     o_dp_out,
`endif
  output logic [4*DIGITS-1:0]   o_value,
  output logic                  o_value_vld,
  output logic [DIGITS-1:0]     o_digit_err
);
  localparam int CW = $clog2(STABLE_CYC);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
`ifdef SS_SCAN_DP_EN
  localparam int SW = DIGITS + 8;
`else
  localparam int SW = DIGITS + 7;
`endif
  logic [SW-1:0]         w_pin, r_s1, r_s2, r_prev;
  logic [CW-1:0]         r_cnt, w_cnt_nxt;
  logic                  r_cap, w_cap, w_one, w_diff, w_bad, w_done;
  logic [DIGITS-1:0]     w_sel, w_stg_err, r_stg_err, w_mask, r_mask;
  logic [IW-1:0]         w_idx;
  logic [3:0]            w_nib;
  logic [6:0]            w_seg;
  logic [4*DIGITS-1:0]   w_stg_val, r_stg_val;
`ifdef SS_SCAN_DP_EN
  logic [DIGITS-1:0]     w_stg_dp, r_stg_dp;
  assign w_pin = {i_dp, i_an, i_seg};
`else
  assign w_pin = {i_an, i_seg};
`endif
  assign w_seg = r_s2[6:0];
  assign w_sel = ~r_s2[7 +: DIGITS];
  always_comb begin
    w_one  = (w_sel != '0) && ((w_sel & (w_sel - DIGITS'(1))) == '0);
    w_idx  = '0;
    for (int i = 0; i < DIGITS; i++)
      if (w_sel[i]) w_idx = IW'(i);
    w_diff    = r_s2 != r_prev;
    w_cnt_nxt = (w_diff || !w_one) ? '0 :
                (r_cnt == CW'(STABLE_CYC-1)) ? r_cnt : r_cnt + 1'b1;
    // only the first arrival at the saturation value captures; the flag blocks repeats
    w_cap = w_one && !r_cap && (w_cnt_nxt == CW'(STABLE_CYC-1));
  end
  always_comb begin
    w_bad = 1'b0;
    case (w_seg)
      7'b1000000: w_nib = 4'h0;
      7'b1111001: w_nib = 4'h1;
      7'b0100100: w_nib = 4'h2;
      7'b0110000: w_nib = 4'h3;
      7'b0011001: w_nib = 4'h4;
      7'b0010010: w_nib = 4'h5;
      7'b0000010: w_nib = 4'h6;
      7'b1111000: w_nib = 4'h7;
      7'b0000000: w_nib = 4'h8;
      7'b0011000: w_nib = 4'h9;
      7'b0001000: w_nib = 4'hA;
      7'b0000011: w_nib = 4'hB;
      7'b1000110: w_nib = 4'hC;
      7'b0100001: w_nib = 4'hD;
      7'b0000110: w_nib = 4'hE;
      7'b0001110: w_nib = 4'hF;
      default: begin
        w_nib = 4'h0;
        w_bad = 1'b1;
      end
    endcase
  end
  // staging image as it will look after this edge's capture, so a completing
  // frame includes the digit captured on the same edge
  always_comb begin
    w_stg_val = r_stg_val;
    w_stg_val[4*w_idx +: 4] = w_nib;
    w_stg_err = r_stg_err;
    w_stg_err[w_idx] = w_bad;
`ifdef SS_SCAN_DP_EN
    w_stg_dp = r_stg_dp;
    w_stg_dp[w_idx] = ~r_s2[SW-1];
`endif
    w_mask = r_mask | w_sel;
    w_done = w_cap && (w_mask == '1);
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1        <= '0;
      r_s2        <= '0;
      r_prev      <= '0;
      r_cnt       <= '0;
      r_cap       <= 1'b0;
      r_stg_val   <= '0;
      r_stg_err   <= '0;
      r_mask      <= '0;
      o_value     <= '0;
      o_value_vld <= 1'b0;
      o_digit_err <= '0;
`ifdef SS_SCAN_DP_EN
      r_stg_dp    <= '0;
      o_dp_out    <= '0;
`endif
    end else begin
      r_s1        <= w_pin;
      r_s2        <= r_s1;
      r_prev      <= r_s2;
      r_cnt       <= w_cnt_nxt;
      r_cap       <= (w_diff || !w_one) ? 1'b0 : (r_cap | w_cap);
      o_value_vld <= w_done;
      if (w_cap) begin
        r_stg_val <= w_stg_val;
        r_stg_err <= w_stg_err;
        r_mask    <= w_done ? '0 : w_mask;
`ifdef SS_SCAN_DP_EN
        r_stg_dp  <= w_stg_dp;
`endif
      end
      if (w_done) begin
        o_value     <= w_stg_val;
        o_digit_err <= w_stg_err;
`ifdef SS_SCAN_DP_EN
        o_dp_out    <= w_stg_dp;
`endif
      end
    end
  end
endmodule

// File: tb/tb_ss_scan_decoder.sv
// tb_ss_scan_decoder: directed and randomized scans checked against a dwell-level model
module tb_ss_scan_decoder;
  localparam int SC = 8;
  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [15:0] value;
  logic        vld;
  logic [3:0]  derr;
  ss_scan_decoder #(.DIGITS(4), .STABLE_CYC(SC)) dut (
    .i_clk(clk), .i_rst(rst), .i_seg(seg), .i_an(an),
    .o_value(value), .o_value_vld(vld), .o_digit_err(derr)
  );
  always #5 clk = ~clk;
  logic [6:0] enc [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
  int n_vec = 0, n_err = 0, vld_cnt = 0, exp_pulses = 0;
  logic [3:0]  m_nib [4];
  logic [3:0]  m_err, m_mask, exp_err, last_an;
  logic [15:0] exp_val;
  logic [6:0]  last_seg;
  always @(negedge clk) if (vld === 1'b1) vld_cnt++;
  task automatic decode(input logic [6:0] p, output logic [3:0] nib, output logic bad);
    nib = 4'h0;
    bad = 1'b1;
    for (int k = 0; k < 16; k++)
      if (enc[k] == p) begin
        nib = k[3:0];
        bad = 1'b0;
      end
  endtask
  task automatic dwell(input logic [3:0] a, input logic [6:0] s, input int n);
    logic [3:0] nb;
    logic       bd;
    int         d;
    an = a;
    seg = s;
    repeat (n) @(negedge clk);
    last_an = a;
    last_seg = s;
    if ($countones(~a) == 1 && n >= SC) begin
      d = 0;
      for (int k = 0; k < 4; k++) if (!a[k]) d = k;
      decode(s, nb, bd);
      m_nib[d] = nb;
      m_err[d] = bd;
      m_mask[d] = 1'b1;
      if (m_mask == 4'hF) begin
        exp_val = {m_nib[3], m_nib[2], m_nib[1], m_nib[0]};
        exp_err = m_err;
        exp_pulses++;
        m_mask = 4'h0;
      end
    end
  endtask
  task automatic do_reset();
    an = 4'hF;
    seg = 7'h7F;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    m_mask = 4'h0;
    exp_val = 16'h0;
    exp_err = 4'h0;
    last_an = 4'hF;
    last_seg = 7'h7F;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic check(input string tag);
    chk({tag, " pulses"}, vld_cnt, exp_pulses);
    chk({tag, " value"}, {16'h0, value}, {16'h0, exp_val});
    chk({tag, " err"}, {28'h0, derr}, {28'h0, exp_err});
  endtask
  task automatic scan(input logic [27:0] p, input int n1);
    for (int d = 3; d >= 0; d--)
      dwell(~(4'b0001 << d), p[7*d +: 7], d == 1 ? n1 : 20);
  endtask
  initial begin
    logic [3:0] a;
    logic [6:0] s;
    int         n;
    for (int k = 0; k < 4; k++) m_nib[k] = 4'h0;
    m_err = 4'h0;
    an = 4'hF;
    seg = 7'h7F;
    rst = 1'b1;
    @(negedge clk);
    do_reset();
    check("reset");
    chk("reset vld", {31'h0, vld}, 32'h0);
    scan({enc[3], enc[2], enc[1], enc[0]}, 20);
    check("scan3210");
    chk("scan3210 const", {16'h0, value}, 32'h3210);
    chk("scan3210 err const", {28'h0, derr}, 32'h0);
    scan({enc[7], enc[6], enc[5], enc[4]}, 6);
    check("short d1");
    chk("short d1 const", vld_cnt, 32'd1);
    scan({enc[7], enc[6], enc[5], enc[4]}, 20);
    check("after short");
    chk("after short const", {16'h0, value}, 32'h7654);
    do_reset();
    scan({enc[3], 7'h7F, enc[1], enc[0]}, 20);
    check("blank d2");
    chk("blank d2 const", {16'h0, value}, 32'h3010);
    chk("blank d2 err const", {28'h0, derr}, 32'h4);
    dwell(4'b0011, enc[8], 50);
    dwell(4'hF, 7'h7F, 10);
    check("two active");
    scan({enc[9], enc[8], enc[7], enc[6]}, 20);
    check("after two active");
    chk("after two active const", {16'h0, value}, 32'h9876);
    dwell(4'b1110, enc[1], 20);
    dwell(4'b1101, enc[2], 20);
    dwell(4'b1011, enc[3], 20);
    do_reset();
    chk("mid rst value", {16'h0, value}, 32'h0);
    dwell(4'b0111, enc[4], 20);
    dwell(4'hF, 7'h7F, 10);
    check("rst partial");
    scan({enc[10], enc[11], enc[12], enc[13]}, 20);
    check("abcd");
    chk("abcd const", {16'h0, value}, 32'hABCD);
    dwell(4'b1110, enc[5], 20);
    dwell(4'b1101, enc[1], 20);
    dwell(4'b1110, enc[9], 20);
    dwell(4'b1011, enc[2], 20);
    dwell(4'b0111, enc[3], 20);
    check("latest wins");
    chk("latest wins const", {16'h0, value}, 32'h3219);
    dwell(4'b0111, enc[1], 20);
    dwell(4'b1011, enc[2], 20);
    dwell(4'b1101, enc[3], 20);
    dwell(4'b1110, enc[4], SC - 1);
    dwell(4'hF, 7'h7F, 4);
    check("dwell 7");
    dwell(4'b1110, enc[4], SC);
    dwell(4'hF, 7'h7F, 4);
    check("dwell 8");
    chk("dwell 8 const", {16'h0, value}, 32'h1234);
    do_reset();
    for (int t = 0; t < 150; t++) begin
      n = $urandom_range(0, 9);
      a = n < 7 ? ~(4'b0001 << $urandom_range(0, 3)) : n == 7 ? 4'hF : 4'($urandom_range(0, 15));
      s = $urandom_range(0, 3) == 0 ? 7'($urandom) : enc[$urandom_range(0, 15)];
      if (a == last_an && s == last_seg) s = s ^ 7'h01;
      n = $urandom_range(0, 2) == 0 ? $urandom_range(1, SC - 1) : $urandom_range(SC + 4, 25);
      dwell(a, s, n);
      check("random");
      if (t == 75) begin
        do_reset();
        check("random rst");
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
